// File: rtl/regfile_writeback_queue_if.sv
// Write-request channel from execute/load units into the writeback queue.
// valid/ready handshake; addr/data are the destination register and value.
// master: producer side (drives valid/addr/data); slave: queue side (drives ready).
interface regfile_writeback_queue_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_writeback_queue.sv
// Purpose: circular FIFO of register-file writes feeding the single write port, with newest-first bypass lookup.
// Latency: write accepted at edge N drives rf_we before edge N+1 at the earliest; no same-cycle pass-through.
// Backpressure: wr.ready = not full (or coalesce hit); purely state-based, independent of hold and same-cycle pop.
//
// Ports: clk, rst (synchronous, active high); wr (slave write channel); hold (freeze draining);
//        rf_we/rf_waddr/rf_wdata (register file write port); lk_addr1/2 -> lk_hit1/2, lk_data1/2 (bypass);
//        pending (occupied entries), empty.
// Optional build macro WB_COALESCE_EN: a write to the same address as the newest entry overwrites it in place.
module regfile_writeback_queue #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_writeback_queue_if.slave wr,
    input  logic                     hold,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [ADDR_W-1:0]        lk_addr1,
    output logic                     lk_hit1,
    output logic [DATA_W-1:0]        lk_data1,
    input  logic [ADDR_W-1:0]        lk_addr2,
    output logic                     lk_hit2,
    output logic [DATA_W-1:0]        lk_data2,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               coal_hit;
    logic               alloc;
    logic               pop;
    logic               nonempty;
    logic [PTR_W-1:0]   idx;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0]   newest;
    logic               coal_fire;

    // The newest entry may only be rewritten when it is not leaving on this
    // edge: with two or more entries the head is older, with one it must be held.
    always_comb begin
        newest   = tail - PTR_W'(1);
        coal_hit = (count != '0) && (mem[newest].addr == wr.addr)
                   && ((count >= CNT_W'(2)) || hold);
    end
    assign coal_fire = wr.valid && coal_hit && !rst;
`else
    assign coal_hit = 1'b0;
`endif

    assign nonempty = (count != '0);
    assign wr.ready = (count < CNT_W'(DEPTH)) || coal_hit;
    assign alloc    = wr.valid && wr.ready && !coal_hit && !rst;

    // Drain is combinational from the head; the register file captures it on
    // the same edge that pops the entry.
    assign rf_we    = !rst && nonempty && !hold;
    assign pop      = rf_we;
    assign rf_waddr = (!rst && nonempty) ? mem[head].addr : '0;
    assign rf_wdata = (!rst && nonempty) ? mem[head].data : '0;

    assign pending  = count;
    assign empty    = (count == '0);

    // Scan oldest to newest so the last match (youngest entry) wins. The head
    // is included even when popping: the register file only updates at the edge.
    always_comb begin
        lk_hit1  = 1'b0;
        lk_data1 = '0;
        lk_hit2  = 1'b0;
        lk_data2 = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (!rst && (CNT_W'(k) < count)) begin
                if (mem[idx].addr == lk_addr1) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = mem[idx].data;
                end
                if (mem[idx].addr == lk_addr2) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = mem[idx].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) tail <= tail + PTR_W'(1);
            if (pop)   head <= head + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; validity is tracked purely by head/count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem[tail].addr <= wr.addr;
            mem[tail].data <= wr.data;
        end
`ifdef WB_COALESCE_EN
        if (coal_fire) mem[newest].data <= wr.data;
`endif
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;
    logic       clk;
    logic       rst;
    logic       hold;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic [1:0] lk_addr1, lk_addr2;
    logic       lk_hit1, lk_hit2;
    logic [3:0] lk_data1, lk_data2;
    logic [2:0] pending;
    logic       empty;

    regfile_writeback_queue_if #(.ADDR_W(2), .DATA_W(4)) wr_if ();

    regfile_writeback_queue #(.DATA_W(4), .ADDR_W(2), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr_if),
        .hold     (hold),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .lk_addr1 (lk_addr1),
        .lk_hit1  (lk_hit1),
        .lk_data1 (lk_data1),
        .lk_addr2 (lk_addr2),
        .lk_hit2  (lk_hit2),
        .lk_data2 (lk_data2),
        .pending  (pending),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         failures;
    logic [5:0] exp_q [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every register-file write must match the oldest expected one.
    task automatic monitor();
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rf_we) begin
                if (rst) begin
                    chk("we_during_reset", {7'd0, rf_we}, 8'd0);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_order", {2'b00, rf_waddr, rf_wdata}, {2'b00, e});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write and hold it until accepted; sb=1 records the expected write.
    task automatic send(input logic [1:0] a, input logic [3:0] d, input bit sb);
        bit ok;
        ok = 1'b0;
        wr_if.valid = 1'b1;
        wr_if.addr  = a;
        wr_if.data  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wr_if.ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", {7'd0, ok}, 8'd1);
        if (ok && sb) exp_q.push_back({a, d});
        tick();
        wr_if.valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (empty && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drained", {7'd0, done}, 8'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        hold        = 1'b0;
        wr_if.valid = 1'b1;
        wr_if.addr  = 2'd3;
        wr_if.data  = 4'hF;
        lk_addr1    = 2'd0;
        lk_addr2    = 2'd0;
        fork
            monitor();
        join_none

        // Reset held two cycles with a request pending.
        @(posedge clk);
        @(negedge clk);
        chk("rst_we", {7'd0, rf_we}, 8'd0);
        chk("rst_ready", {7'd0, wr_if.ready}, 8'd1);
        chk("rst_pending", {5'd0, pending}, 8'd0);
        chk("rst_empty", {7'd0, empty}, 8'd1);
        tick();
        rst = 1'b0;
        wr_if.valid = 1'b0;
        tick();

        // Single write appears one cycle after acceptance.
        send(2'd2, 4'hA, 1'b1);
        chk("lat_we", {7'd0, rf_we}, 8'd1);
        chk("lat_waddr", {6'd0, rf_waddr}, 8'd2);
        chk("lat_wdata", {4'd0, rf_wdata}, 8'hA);
        tick();
        chk("lat_pending", {5'd0, pending}, 8'd0);

        // Fill under hold, fifth write stalls, then everything drains in order.
        hold = 1'b1;
        send(2'd1, 4'h1, 1'b1);
        send(2'd2, 4'h2, 1'b1);
        send(2'd3, 4'h3, 1'b1);
        send(2'd0, 4'h4, 1'b1);
        chk("full_pending", {5'd0, pending}, 8'd4);
        chk("full_ready", {7'd0, wr_if.ready}, 8'd0);
        wr_if.valid = 1'b1;
        wr_if.addr  = 2'd1;
        wr_if.data  = 4'h6;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("stall_ready", {7'd0, wr_if.ready}, 8'd0);
        end
        tick();
        hold = 1'b0;
        send(2'd1, 4'h6, 1'b1);
        drain();

        // Bypass returns the youngest of two writes to the same address.
        hold = 1'b1;
`ifdef WB_COALESCE_EN
        send(2'd1, 4'h5, 1'b0);
`else
        send(2'd1, 4'h5, 1'b1);
`endif
        send(2'd1, 4'h9, 1'b1);
        lk_addr1 = 2'd1;
        lk_addr2 = 2'd3;
        @(negedge clk);
        chk("byp_hit1", {7'd0, lk_hit1}, 8'd1);
        chk("byp_data1", {4'd0, lk_data1}, 8'h9);
        chk("byp_hit2", {7'd0, lk_hit2}, 8'd0);
        chk("byp_data2", {4'd0, lk_data2}, 8'h0);
        tick();
        hold = 1'b0;
        drain();

        // Back-to-back pushes with draining: occupancy stays at one through wrap.
        for (int i = 0; i < 10; i++) begin
            send(2'(i % 4), 4'(i + 1), 1'b1);
            chk("stream_pending", {5'd0, pending}, 8'd1);
        end
        drain();

        // Reset mid-operation discards pending entries.
        hold = 1'b1;
        send(2'd0, 4'h1, 1'b0);
        send(2'd1, 4'h2, 1'b0);
        send(2'd2, 4'h3, 1'b0);
        lk_addr1 = 2'd1;
        lk_addr2 = 2'd2;
        @(negedge clk);
        chk("pre_rst_pending", {5'd0, pending}, 8'd3);
        chk("pre_rst_data1", {4'd0, lk_data1}, 8'h2);
        tick();
        rst  = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", {7'd0, rf_we}, 8'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_pending", {5'd0, pending}, 8'd0);
        chk("post_rst_hit1", {7'd0, lk_hit1}, 8'd0);
        chk("post_rst_hit2", {7'd0, lk_hit2}, 8'd0);
        chk("post_rst_empty", {7'd0, empty}, 8'd1);
        tick();
        tick();
        tick();

        // Two writes to the same address while held.
        hold = 1'b1;
`ifdef WB_COALESCE_EN
        send(2'd2, 4'h3, 1'b0);
`else
        send(2'd2, 4'h3, 1'b1);
`endif
        send(2'd2, 4'h7, 1'b1);
        lk_addr1 = 2'd2;
        @(negedge clk);
`ifdef WB_COALESCE_EN
        chk("coal_pending", {5'd0, pending}, 8'd1);
`else
        chk("coal_pending", {5'd0, pending}, 8'd2);
`endif
        chk("coal_data1", {4'd0, lk_data1}, 8'h7);
        tick();
        hold = 1'b0;
        drain();

        chk("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Producer-side driver for the 4-bit, 4-entry register file's single write port (we/waddr/wdata).
- Accepts result writes from execute/load units over a valid/ready handshake.
- Buffers them in a small circular FIFO and drains at most one write per cycle into the register file.
- Provides newest-first bypass lookup on two read addresses, so the register file read ports plus this block always yield architecturally current values.

Parameters:
DATA_W, 4, data width; matches register file wdata.
ADDR_W, 2, register address width; matches waddr/raddr.
DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  producer has a write request.
in_ready  out  1  queue can accept this cycle.
in_addr  in  ADDR_W  destination register.
in_data  in  DATA_W  value to write.
hold  in  1  suppress draining this cycle (register file port busy or debug freeze).
rf_we  out  1  connects to register file we.
rf_waddr  out  ADDR_W  connects to waddr.
rf_wdata  out  DATA_W  connects to wdata.
lk_addr1  in  ADDR_W  bypass lookup address 1, tied to raddr1.
lk_hit1  out  1  a pending write to lk_addr1 exists.
lk_data1  out  DATA_W  newest pending data for lk_addr1; 0 when no hit.
lk_addr2  in  ADDR_W  bypass lookup address 2.
lk_hit2  out  1  same as lk_hit1, for lk_addr2.
lk_data2  out  DATA_W  same as lk_data1, for lk_addr2.
pending  out  log2(DEPTH)+1  occupied entries.
empty  out  1  pending==0.

Behaviour:
- Storage: DEPTH entries of {addr,data}, head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH, separate count register.
- Accept: handshake fires on the edge where in_valid&&in_ready. Entry is written at tail; tail increments; count increments unless a pop occurs on the same edge.
- in_ready = (count<DEPTH), or a coalesce hit (see Optional Feature). in_ready is purely state-based and does not depend on hold or on a same-cycle pop, so a full queue never accepts non-coalescing writes.
- Drain (combinational from head): rf_we = !rst && count!=0 && !hold; rf_waddr/rf_wdata = head entry (0 when empty).
- Pop occurs on the same edge the register file captures the write; head increments.
- Latency: a write accepted at edge N reaches the register file at edge N+1 at the earliest (empty queue, hold=0). No same-cycle pass-through.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push and pop at count==1: the new entry becomes head on the next cycle.
- Bypass: lk_hitK=1 if any valid entry has addr==lk_addrK. lk_dataK is the data of the youngest such entry, scanned tail-1 back to head.
  - Includes the head entry being popped this cycle, because the register file updates only at the edge.
  - Excludes the entry being accepted this cycle; it becomes visible next cycle.
- Same-address ordering: writes retire strictly in acceptance order, so the final register value equals the last accepted write.
- Reset: count=0, head=tail=0, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, lk_hit*=0, lk_data*=0, pending=0, empty=1.
  - Reset mid-operation discards all pending entries; no write is issued in any cycle where rst=1.
  - Entry storage contents need not be cleared.
- hold high with count==DEPTH: the queue stays full, in_ready=0 and no state changes, except for coalesce.

Optional Feature:
WB_COALESCE_EN
- Defined: an incoming write whose in_addr equals the tail-1 (newest) entry's addr overwrites that entry's data in place. No pointer or count change.
  - Applies only when that entry is not being popped this edge: count>=2, or count==1 with hold=1.
  - in_ready is also asserted on such a hit when full.
  - Bypass returns the coalesced data the next cycle.
- Undefined: every accepted write allocates a new entry. in_ready = count<DEPTH only.

Test Plan:
- Reset with rst=1 for 2 cycles while in_valid=1 -> rf_we=0, in_ready=1, pending=0, empty=1. After release, write {addr=2,data=0xA} -> rf_we=1, waddr=2, wdata=0xA exactly one cycle later; pending returns to 0.
- hold=1, push 4 writes (1:0x1, 2:0x2, 3:0x3, 0:0x4) -> pending=4, in_ready=0, 5th write to addr 1 stalls. Release hold -> four rf_we pulses in order 1,2,3,0 on consecutive cycles, and the stalled write follows.
- hold=1, push {1:0x5},{1:0x9}, lk_addr1=1 -> lk_hit1=1, lk_data1=0x9. lk_addr2=3 -> lk_hit2=0, lk_data2=0.
- Continuous push every cycle with hold=0 over 10 writes -> pending stays at 1. Pointers wrap past DEPTH-1 without loss; rf_wdata sequence equals input sequence.
- Fill to 3 entries, assert rst for 1 cycle -> no rf_we during or after reset, pending=0, lk_hit1=lk_hit2=0.
- WB_COALESCE_EN: hold=1, push {2:0x3},{2:0x7} -> pending=1, lk_data1(addr 2)=0x7. Release hold -> a single rf_we with wdata=0x7. Without the macro: pending=2, two writes 0x3 then 0x7.
